// File: rtl/pwm_audio_pkg.sv
// Shared definitions for the audio PWM block: command codes, device number,
// reset sample level and STATUS bit layout.
package pwm_audio_pkg;

   typedef enum logic [1:0] {
      CMD_PUSH = 2'b00,
      CMD_RATE = 2'b01,
      CMD_CTRL = 2'b10,
      CMD_NOP  = 2'b11
   } cmd_e;

   localparam logic [3:0] DEV_PWM    = 4'hE;
   localparam logic [7:0] SAMPLE_MID = 8'h80;

   localparam int unsigned ST_ENABLE   = 7;
   localparam int unsigned ST_UNDERRUN = 6;
   localparam int unsigned ST_OVERFLOW = 5;
   localparam int unsigned ST_CNT_W    = 3;

endpackage

// File: rtl/pwm_fifo.sv
// Sample FIFO with first-word-fall-through head, push/pop/flush and occupancy.
// A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module pwm_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   assign pop_ok  = pop_i && !empty_o && !flush_i;
   assign push_ok = push_i && (!full_o || pop_ok) && !flush_i;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_ok) wr_d = wr_q + 1'b1;
         if (pop_ok)  rd_d = rd_q + 1'b1;
         cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/pwm_audio.sv
// Audio PWM generator: decodes extended ctrl writes, buffers samples and
// plays them as an 8-bit registered PWM waveform at a programmable rate.
module pwm_audio
   import pwm_audio_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter logic [3:0]  DEVCODE = DEV_PWM
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CTRL_STB,
   input  logic [15:0] CTRL_ADDR,
   output logic        PWM,
   output logic [7:0]  STATUS
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   cmd_e          cmd;
   logic          hit, do_push, do_rate, do_ctrl, do_flush;
   logic          wrap, tick, pop;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_head;
   logic [CW-1:0] fifo_cnt;

   logic       enable_q, enable_d;
   logic       underrun_q, underrun_d;
   logic       overflow_q, overflow_d;
   logic [7:0] cur_q, cur_d;
   logic [7:0] rate_q, rate_d;
   logic [7:0] phase_q, phase_d;
   logic [7:0] div_q, div_d;
   logic       pwm_q, pwm_d;

   assign cmd      = cmd_e'(CTRL_ADDR[1:0]);
   assign hit      = CTRL_STB && (CTRL_ADDR[3:2] == 2'b00) && (CTRL_ADDR[7:4] == DEVCODE);
   assign do_push  = hit && (cmd == CMD_PUSH);
   assign do_rate  = hit && (cmd == CMD_RATE);
   assign do_ctrl  = hit && (cmd == CMD_CTRL);
   assign do_flush = do_ctrl && CTRL_ADDR[9];

   // A flush suppresses the tick so nothing is popped into cur alongside the reset.
   assign wrap = enable_q && (phase_q == 8'hFF);
   assign tick = wrap && (div_q == '0) && !do_flush;
   assign pop  = tick && !fifo_empty;

   pwm_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (do_push),
      .pop_i   (pop),
      .flush_i (do_flush),
      .data_i  (CTRL_ADDR[15:8]),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_comb begin
      enable_d   = enable_q;
      underrun_d = underrun_q;
      overflow_d = overflow_q;
      cur_d      = cur_q;
      rate_d     = rate_q;
      phase_d    = enable_q ? phase_q + 8'd1 : '0;
      div_d      = div_q;
      pwm_d      = enable_q && (phase_q < cur_q);

      if (wrap) div_d = (div_q == '0) ? rate_q : div_q - 8'd1;
      if (tick && fifo_empty) underrun_d = 1'b1;
      if (pop) cur_d = fifo_head;
      if (do_push && fifo_full && !pop) overflow_d = 1'b1;
      if (do_rate) rate_d = CTRL_ADDR[15:8];
      if (do_ctrl) enable_d = CTRL_ADDR[8];
      if (do_flush) begin
         underrun_d = 1'b0;
         overflow_d = 1'b0;
         cur_d      = SAMPLE_MID;
         phase_d    = '0;
         div_d      = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         enable_q   <= 1'b0;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
         cur_q      <= SAMPLE_MID;
         rate_q     <= '0;
         phase_q    <= '0;
         div_q      <= '0;
         pwm_q      <= 1'b0;
      end else begin
         enable_q   <= enable_d;
         underrun_q <= underrun_d;
         overflow_q <= overflow_d;
         cur_q      <= cur_d;
         rate_q     <= rate_d;
         phase_q    <= phase_d;
         div_q      <= div_d;
         pwm_q      <= pwm_d;
      end
   end

   assign PWM = pwm_q;

   always_comb begin
      STATUS              = '0;
      STATUS[ST_ENABLE]   = enable_q;
      STATUS[ST_UNDERRUN] = underrun_q;
      STATUS[ST_OVERFLOW] = overflow_q;
      STATUS[2:0]         = 3'(fifo_cnt);
   end

endmodule

// File: tb/tb_pwm_audio.sv
// Self-checking bench for pwm_audio: a queue-based behavioural model checked
// every cycle, plus directed duty-cycle, timing and STATUS expectations.
module tb_pwm_audio;
   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CTRL_STB;
   logic [15:0] CTRL_ADDR;
   logic        PWM;
   logic [7:0]  STATUS;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit chk_on   = 1'b0;

   pwm_audio #(.DEPTH(DEPTH), .DEVCODE(4'hE)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .CTRL_STB  (CTRL_STB),
      .CTRL_ADDR (CTRL_ADDR),
      .PWM       (PWM),
      .STATUS    (STATUS)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   // Behavioural model: sample queue, phase/divider as plain integers.
   bit m_en = 0, m_und = 0, m_ovf = 0, m_pwm = 0;
   int m_cur = 128, m_rate = 0, m_phase = 0, m_div = 0;
   int m_q[$];

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_en = 0; m_und = 0; m_ovf = 0; m_pwm = 0;
         m_cur = 128; m_rate = 0; m_phase = 0; m_div = 0;
         m_q.delete();
      end else begin
         bit hit, push, ratew, ctrl, flush, wrap, tick;
         int nphase, ndiv, data;
         m_pwm  = m_en && (m_phase < m_cur);
         hit    = CTRL_STB && (CTRL_ADDR[3:2] == 2'b00) && (CTRL_ADDR[7:4] == 4'hE);
         push   = hit && (CTRL_ADDR[1:0] == 2'd0);
         ratew  = hit && (CTRL_ADDR[1:0] == 2'd1);
         ctrl   = hit && (CTRL_ADDR[1:0] == 2'd2);
         flush  = ctrl && CTRL_ADDR[9];
         data   = int'(CTRL_ADDR[15:8]);
         wrap   = m_en && (m_phase == 255);
         tick   = wrap && (m_div == 0) && !flush;
         nphase = m_en ? (m_phase + 1) % 256 : 0;
         ndiv   = wrap ? ((m_div == 0) ? m_rate : m_div - 1) : m_div;
         if (tick) begin
            if (m_q.size() > 0) m_cur = m_q.pop_front();
            else m_und = 1;
         end
         if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(data);
            else m_ovf = 1;
         end
         if (ratew) m_rate = data;
         if (ctrl) m_en = CTRL_ADDR[8];
         m_phase = nphase;
         m_div   = ndiv;
         if (flush) begin
            m_q.delete();
            m_und = 0; m_ovf = 0; m_cur = 128; m_phase = 0; m_div = 0;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_on) begin
         logic [7:0] ms;
         ms = {m_en, m_und, m_ovf, 2'b00, 3'(m_q.size())};
         checks++;
         if (PWM !== m_pwm) begin
            failures++;
            if (failures < 30) $display("FAIL model_pwm cyc=%0d got=%b exp=%b", cyc, PWM, m_pwm);
         end
         checks++;
         if (STATUS !== ms) begin
            failures++;
            if (failures < 30) $display("FAIL model_status cyc=%0d got=%h exp=%h", cyc, STATUS, ms);
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   function automatic logic [15:0] a_push(input logic [7:0] d);
      return {d, 8'hE0};
   endfunction
   function automatic logic [15:0] a_rate(input logic [7:0] r);
      return {r, 8'hE1};
   endfunction
   function automatic logic [15:0] a_ctrl(input bit en, input bit fl);
      return {6'b0, fl, en, 8'hE2};
   endfunction

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic wr(input logic [15:0] a);
      CTRL_ADDR = a;
      CTRL_STB  = 1'b1;
      @(posedge CLK); #1;
      CTRL_STB  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic count_high(input int n, output int hi);
      hi = 0;
      repeat (n) begin
         @(negedge CLK);
         hi += int'(PWM);
      end
      @(posedge CLK); #1;
   endtask

   int hi;
   int t0;
   int tp[3];
   int npop;
   logic [2:0] prev;

   initial begin
      RST = 1'b1; CTRL_STB = 1'b0; CTRL_ADDR = '0;
      @(posedge CLK); #1;
      chk_on = 1'b1;
      @(posedge CLK); #1;
      chk("reset_status", int'(STATUS), 8'h00);
      chk("reset_pwm", int'(PWM), 0);
      RST = 1'b0;

      count_high(1000, hi);
      chk("idle_pwm_high", hi, 0);
      chk("idle_status", int'(STATUS), 8'h00);

      wr(a_ctrl(1, 0));
      idle(2);
      count_high(256, hi);
      chk("empty_mid_duty", hi, 128);
      wr(a_ctrl(0, 1));
      chk("flush_off_status", int'(STATUS), 8'h00);

      wr(a_push(8'h00)); wr(a_push(8'h40)); wr(a_push(8'hFF));
      wr(a_ctrl(1, 0));
      idle(257);
      count_high(256, hi); chk("duty_00", hi, 0);
      count_high(256, hi); chk("duty_40", hi, 64);
      count_high(256, hi); chk("duty_ff", hi, 255);
      count_high(256, hi); chk("duty_ff_hold", hi, 255);
      chk("underrun_status", int'(STATUS), 8'hC0);
      wr(a_ctrl(0, 1));

      wr(a_push(8'h11)); wr(a_push(8'h22)); wr(a_push(8'h33));
      wr(a_push(8'h44)); wr(a_push(8'h55));
      chk("overflow_status", int'(STATUS), 8'h24);
      wr(a_ctrl(1, 0));
      idle(1281);
      count_high(256, hi);
      chk("dropped_never_played", hi, 8'h44);
      wr(a_ctrl(0, 1));

      wr(a_push(8'h01)); wr(a_push(8'h02)); wr(a_push(8'h03)); wr(a_push(8'h04));
      chk("full_status", int'(STATUS), 8'h04);
      wr(a_ctrl(1, 0));
      idle(255);
      wr(a_push(8'h99));
      chk("push_in_pop_cycle", int'(STATUS), 8'h84);
      wr(a_ctrl(0, 1));

      wr(a_push(8'h10)); wr(a_push(8'h20)); wr(a_push(8'h30));
      wr(a_push(8'h40)); wr(a_push(8'h50));
      wr(a_rate(8'd3));
      wr(a_ctrl(1, 0));
      t0 = cyc;
      prev = STATUS[2:0];
      npop = 0;
      for (int i = 0; i < 4000 && npop < 3; i++) begin
         @(negedge CLK);
         if (STATUS[2:0] != prev) begin
            tp[npop] = cyc;
            npop++;
            prev = STATUS[2:0];
         end
      end
      @(posedge CLK); #1;
      chk("rate3_pops_seen", npop, 3);
      if (npop == 3) begin
         chk("rate3_first_pop", tp[0] - t0, 256);
         chk("rate3_gap1", tp[1] - tp[0], 1024);
         chk("rate3_gap2", tp[2] - tp[1], 1024);
      end

      wr(a_ctrl(1, 1));
      chk("flush_mid_status", int'(STATUS), 8'h80);
      idle(1);
      count_high(256, hi);
      chk("flush_mid_duty", hi, 128);

      idle(5);
      chk("pre_reset_pwm", int'(PWM), 1);
      RST = 1'b1;
      #1;
      chk("async_reset_pwm", int'(PWM), 0);
      chk("async_reset_status", int'(STATUS), 8'h00);
      @(posedge CLK); #1;
      RST = 1'b0;
      wr(a_ctrl(1, 0));
      idle(2);
      count_high(256, hi);
      chk("post_reset_duty", hi, 128);
      wr(a_ctrl(0, 1));

      wr(16'h05E5); wr(16'h05D1); wr(16'h01E3); wr(16'h01F2);
      wr(16'h55E8); wr(16'h55C0); wr(16'h03D2);
      CTRL_ADDR = a_push(8'h77);
      idle(2);
      chk("ignored_writes_status", int'(STATUS), 8'h00);
      wr(a_push(8'h10)); wr(a_push(8'h20));
      wr(a_ctrl(1, 0));
      idle(257);
      count_high(256, hi); chk("ignored_rate_duty1", hi, 16);
      count_high(256, hi); chk("ignored_rate_duty2", hi, 32);

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
